// File: rtl/temp_ctrl_axil_bank.sv
// AXI4-Lite bank of NUM_CH temperature-control channels.
// Each channel: hysteresis heater FSM, sticky W1C over-temp alarm, irq.

module temp_ctrl_axil_bank #(
   parameter int NUM_CH = 4,
   parameter int TEMP_W = 12,
   parameter int ADDR_W = 9
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
   input  logic                     S_AXI_AWVALID,
   output logic                     S_AXI_AWREADY,
   input  logic [31:0]              S_AXI_WDATA,
   input  logic [3:0]               S_AXI_WSTRB,
   input  logic                     S_AXI_WVALID,
   output logic                     S_AXI_WREADY,
   output logic [1:0]               S_AXI_BRESP,
   output logic                     S_AXI_BVALID,
   input  logic                     S_AXI_BREADY,
   input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
   input  logic                     S_AXI_ARVALID,
   output logic                     S_AXI_ARREADY,
   output logic [31:0]              S_AXI_RDATA,
   output logic [1:0]               S_AXI_RRESP,
   output logic                     S_AXI_RVALID,
   input  logic                     S_AXI_RREADY,
   input  logic [NUM_CH*TEMP_W-1:0] temp_in,
   input  logic [NUM_CH-1:0]        temp_valid,
   output logic [NUM_CH-1:0]        heater_out,
   output logic                     irq
);

   localparam int TW2 = TEMP_W + 2;
   localparam int CW  = ADDR_W - 5;
   localparam logic [TEMP_W-1:0] LIM_RST = {1'b0, {(TEMP_W-1){1'b1}}};
   localparam logic [0:0] ST_OFF  = 1'b0;
   localparam logic [0:0] ST_HEAT = 1'b1;

   logic [2:0]        ctrl_q [NUM_CH];
   logic [2:0]        ctrl_d [NUM_CH];
   logic [TEMP_W-1:0] sp_q   [NUM_CH];
   logic [TEMP_W-1:0] sp_d   [NUM_CH];
   logic [TEMP_W-1:0] hyst_q [NUM_CH];
   logic [TEMP_W-1:0] hyst_d [NUM_CH];
   logic [TEMP_W-1:0] lim_q  [NUM_CH];
   logic [TEMP_W-1:0] lim_d  [NUM_CH];
   logic [TEMP_W-1:0] temp_q [NUM_CH];
   logic [TEMP_W-1:0] temp_d [NUM_CH];
   logic [NUM_CH-1:0] st_q, st_d;
   logic [NUM_CH-1:0] alarm_q, alarm_d;

   logic        aw_rdy_q, aw_rdy_d;
   logic        bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        ar_rdy_q, ar_rdy_d;
   logic        rvalid_q, rvalid_d;
   logic [1:0]  rresp_q, rresp_d;
   logic [31:0] rdata_q, rdata_d;
   logic        wr_fire, ar_fire;

   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return 32'(a) < 32'(NUM_CH * 32);
   endfunction

   function automatic logic [31:0] sext(input logic [TEMP_W-1:0] v);
      return {{(32-TEMP_W){v[TEMP_W-1]}}, v};
   endfunction

   function automatic logic [TEMP_W-1:0] bmerge(
      input logic [TEMP_W-1:0] old,
      input logic [31:0]       d,
      input logic [3:0]        s
   );
      logic [31:0] r;
      r = {{(32-TEMP_W){1'b0}}, old};
      for (int b = 0; b < 4; b++)
         if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r[TEMP_W-1:0];
   endfunction

   function automatic logic [31:0] chan_rd(input int c, input logic [4:0] off);
      case (off)
         5'h00:   return {29'd0, ctrl_q[c]};
         5'h04:   return sext(sp_q[c]);
         5'h08:   return {{(32-TEMP_W){1'b0}}, hyst_q[c]};
         5'h0C:   return sext(lim_q[c]);
         5'h10:   return {30'd0, alarm_q[c], st_q[c]};
         5'h14:   return sext(temp_q[c]);
         default: return 32'd0;
      endcase
   endfunction

   assign wr_fire = aw_rdy_q & S_AXI_AWVALID & S_AXI_WVALID;
   assign ar_fire = ar_rdy_q & S_AXI_ARVALID;

   always_comb begin : chan_next
      logic signed [TW2-1:0] s, sp, hy, lo, hi, lim;
      logic                  wsel;
      st_d    = st_q;
      alarm_d = alarm_q;
      for (int c = 0; c < NUM_CH; c++) begin
         ctrl_d[c] = ctrl_q[c];
         sp_d[c]   = sp_q[c];
         hyst_d[c] = hyst_q[c];
         lim_d[c]  = lim_q[c];
         temp_d[c] = temp_q[c];
         wsel = wr_fire & addr_ok(S_AXI_AWADDR)
              & (S_AXI_AWADDR[ADDR_W-1:5] == CW'(c));
         if (wsel) begin
            case (S_AXI_AWADDR[4:0])
               5'h00: if (S_AXI_WSTRB[0]) ctrl_d[c] = S_AXI_WDATA[2:0];
               5'h04: sp_d[c] = bmerge(sp_q[c], S_AXI_WDATA, S_AXI_WSTRB);
               5'h08: hyst_d[c] = bmerge(hyst_q[c], S_AXI_WDATA, S_AXI_WSTRB);
               5'h0C: lim_d[c] = bmerge(lim_q[c], S_AXI_WDATA, S_AXI_WSTRB);
               5'h10: if (S_AXI_WSTRB[0] & S_AXI_WDATA[1]) alarm_d[c] = 1'b0;
               default: ;
            endcase
         end
         // Widened by two bits so setpoint +/- hysteresis never wraps
         s   = TW2'(signed'(temp_in[c*TEMP_W +: TEMP_W]));
         sp  = TW2'(signed'(sp_q[c]));
         hy  = TW2'(hyst_q[c]);
         lim = TW2'(signed'(lim_q[c]));
         lo  = sp - hy;
         hi  = sp + hy;
         if (temp_valid[c]) begin
            temp_d[c] = temp_in[c*TEMP_W +: TEMP_W];
            if (s > lim) alarm_d[c] = 1'b1;
            if (st_q[c] == ST_OFF && s < lo)
               st_d[c] = ST_HEAT;
            else if (st_q[c] == ST_HEAT && s >= hi)
               st_d[c] = ST_OFF;
         end
         if (!ctrl_q[c][0]) st_d[c] = ST_OFF;
      end
   end

   always_comb begin
      aw_rdy_d = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~aw_rdy_q;
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      if (bvalid_q & S_AXI_BREADY) bvalid_d = 1'b0;
      if (wr_fire) begin
         bvalid_d = 1'b1;
         bresp_d  = addr_ok(S_AXI_AWADDR) ? 2'b00 : 2'b10;
      end
      ar_rdy_d = S_AXI_ARVALID & ~rvalid_q & ~ar_rdy_q;
      rvalid_d = rvalid_q;
      rresp_d  = rresp_q;
      rdata_d  = rdata_q;
      if (rvalid_q & S_AXI_RREADY) rvalid_d = 1'b0;
      if (ar_fire) begin
         rvalid_d = 1'b1;
         rresp_d  = addr_ok(S_AXI_ARADDR) ? 2'b00 : 2'b10;
         rdata_d  = 32'd0;
         for (int c = 0; c < NUM_CH; c++)
            if (addr_ok(S_AXI_ARADDR) && S_AXI_ARADDR[ADDR_W-1:5] == CW'(c))
               rdata_d = chan_rd(c, S_AXI_ARADDR[4:0]);
      end
   end

   always_comb begin
      heater_out = '0;
      irq        = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         heater_out[c] = (st_q[c] == ST_HEAT) | ctrl_q[c][1];
         irq           = irq | (alarm_q[c] & ctrl_q[c][2]);
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_rdy_q <= 1'b0;
         bvalid_q <= 1'b0;
         bresp_q  <= 2'b00;
         ar_rdy_q <= 1'b0;
         rvalid_q <= 1'b0;
         rresp_q  <= 2'b00;
         rdata_q  <= 32'd0;
         st_q     <= '0;
         alarm_q  <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            ctrl_q[c] <= '0;
            sp_q[c]   <= '0;
            hyst_q[c] <= '0;
            lim_q[c]  <= LIM_RST;
            temp_q[c] <= '0;
         end
      end else begin
         aw_rdy_q <= aw_rdy_d;
         bvalid_q <= bvalid_d;
         bresp_q  <= bresp_d;
         ar_rdy_q <= ar_rdy_d;
         rvalid_q <= rvalid_d;
         rresp_q  <= rresp_d;
         rdata_q  <= rdata_d;
         st_q     <= st_d;
         alarm_q  <= alarm_d;
         for (int c = 0; c < NUM_CH; c++) begin
            ctrl_q[c] <= ctrl_d[c];
            sp_q[c]   <= sp_d[c];
            hyst_q[c] <= hyst_d[c];
            lim_q[c]  <= lim_d[c];
            temp_q[c] <= temp_d[c];
         end
      end
   end

   assign S_AXI_AWREADY = aw_rdy_q;
   assign S_AXI_WREADY  = aw_rdy_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = ar_rdy_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RRESP   = rresp_q;
   assign S_AXI_RDATA   = rdata_q;

endmodule

// File: doc/temp_ctrl_axil_bank.md
# temp_ctrl_axil_bank

Parametrised AXI4-Lite slave holding NUM_CH independent temperature-control channels, each with a setpoint, hysteresis band, alarm limit and heater on/off state machine. It replaces the fixed four-register peripheral, adding real control behaviour: per-channel heater drive, sticky over-temperature alarms with write-1-to-clear, and an interrupt. It sits between the processor's AXI interconnect and the sensor front-ends and heater drivers in the block design.

## Interface
- NUM_CH, 4, number of channels (1..16)
- TEMP_W, 12, signed temperature width in bits (8..16)
- ADDR_W, 9, AXI address width; must be ≥ clog2(NUM_CH*32)
- ACLK  in  1  clock
- ARESET  in  1  reset. One clock; reset is synchronous and active-high.
- S_AXI_AWADDR/AWVALID/AWREADY, S_AXI_WDATA(32)/WSTRB(4)/WVALID/WREADY, S_AXI_BRESP(2)/BVALID/BREADY: AXI4-Lite write channels. AWPROT is ignored.
- S_AXI_ARADDR/ARVALID/ARREADY, S_AXI_RDATA(32)/RRESP(2)/RVALID/RREADY: AXI4-Lite read channels. ARPROT is ignored.
- temp_in  in  NUM_CH*TEMP_W  signed samples, channel c at bits [c*TEMP_W +: TEMP_W]
- temp_valid  in  NUM_CH  per-channel sample strobe
- heater_out  out  NUM_CH  heater enable per channel
- irq  out  1  level interrupt

## Operation
- Register map: channel c base = c*0x20.
  - +0x00 CTRL: bit0 enable, bit1 force_on, bit2 irq_en
  - +0x04 SETPOINT: TEMP_W bits, signed
  - +0x08 HYST: TEMP_W bits, unsigned
  - +0x0C ALARM_LIMIT: TEMP_W bits, signed
  - +0x10 STATUS: bit0 heating (RO), bit1 alarm (W1C)
  - +0x14 TEMP: last sample, RO
  - +0x18 and +0x1C: reserved
- Signed fields read back sign-extended to 32 bits. Writes honour WSTRB per byte. Bits above the field width are ignored.
- Address decode:
  - Address ≥ NUM_CH*0x20 → SLVERR (2'b10); no write occurs, RDATA=0.
  - Reserved offsets and RO registers → OKAY; writes dropped, reserved offsets read 0.
- Sample capture: on temp_valid[c], TEMP[c] ← sample.
- Per-channel FSM with states OFF and HEAT. It is evaluated only on temp_valid[c], using the incoming sample s. Comparisons use TEMP_W+2-bit signed arithmetic, so there is no overflow.
  - enable=0: state is forced to OFF every cycle.
  - OFF→HEAT when s < SETPOINT−HYST.
  - HEAT→OFF when s ≥ SETPOINT+HYST.
  - Otherwise the state holds.
- heater_out[c] = (state==HEAT) | force_on. force_on does not alter the FSM.
- Alarm: set when temp_valid[c] & s > ALARM_LIMIT; this works regardless of enable. Writing 1 to STATUS bit1 clears it. A set and a clear in the same cycle resolve to set.
- irq = OR over c of (alarm[c] & irq_en[c]).

## Timing
- Reset values:
  - CTRL=0, SETPOINT=0, HYST=0, ALARM_LIMIT=+max (2^(TEMP_W−1)−1), TEMP=0
  - All FSMs OFF, alarms 0
  - heater_out=0, irq=0
  - AWREADY=WREADY=BVALID=ARREADY=RVALID=0, BRESP=RRESP=0, RDATA=0
- Reset mid-transaction aborts it; no response is issued.
- Write channel:
  - AWREADY and WREADY pulse together for 1 cycle, only when AWVALID & WVALID & !BVALID.
  - The register updates on that edge.
  - BVALID rises the next cycle and is held until BREADY; BRESP is stable while BVALID=1.
  - The next write is not accepted until the cycle after the B handshake.
  - Write throughput is therefore one write per 3 cycles with BREADY held high.
- Read channel:
  - ARREADY pulses for 1 cycle when ARVALID & !RVALID.
  - RDATA/RRESP are registered, with RVALID the next cycle, held until RREADY.
  - Data and response are stable while RVALID=1.
- Read and write are independent and may complete in the same cycle. A read accepted in the same cycle as a write to the same register returns the pre-write value.
- Sample path:
  - temp_valid at edge N → TEMP, state and alarm update at edge N; heater_out and irq change at edge N (registered outputs visible in cycle N+1).
  - A CTRL write of force_on or irq_en takes effect on heater_out and irq in the cycle after the write edge.
- A SETPOINT or HYST change does not move the FSM until the next temp_valid.

## Test plan
- Reset state: after ARESET, read every register of ch0 and ch3. Required: ALARM_LIMIT=0x000007FF, all other registers 0, RRESP=OKAY; heater_out=0 and irq=0.
- Hysteresis control on ch1:
  - Program SETPOINT=400, HYST=10, enable=1.
  - Apply samples 395, 389, 405, 409, 410, 395.
  - Required heater_out[1] after each sample: 0, 1, 1, 1, 0, 0.
- Alarm, W1C and set priority on ch2:
  - Program ALARM_LIMIT=500 and irq_en=1, then apply sample 501. Required: STATUS=0x2 and irq=1.
  - Write STATUS=0x2 in the same cycle as a sample of 600. Required: alarm stays 1.
  - Repeat the write with no new sample. Required: irq=0.
- Byte strobes and sign extension:
  - Write SETPOINT=0xFFFF_F800 with WSTRB=0x3. Required: read back 0xFFFFF800 (−2048).
  - Then write 0x0000_0012 with WSTRB=0x1. Required: read back 0xFFFFF812.
- Decode errors: with NUM_CH=4, write and read address 0x080. Required: BRESP=RRESP=2'b10, RDATA=0, no register changed. A write to 0x014 (TEMP) returns OKAY and is ignored.
- Backpressure and concurrency:
  - Hold BREADY=0 for 5 cycles while a second write is presented. Required: AWREADY stays 0 until 1 cycle after the B handshake.
  - Issue a simultaneous read and write to ch0 SETPOINT. Required: the read returns the old value, and a subsequent read returns the new value.
